// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, memory write port and status bundle for imem_loader
//   master: host/testbench side (drives start, in_valid, in_data)
//   slave : loader side (drives in_ready, mem_we, mem_addr, mem_wdata, busy, done,
//           error, words_written, cpu_reset)
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_written;
    logic                  cpu_reset;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written, cpu_reset
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written, cpu_reset
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into instruction memory words
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : imem_loader_if.slave
//              start/in_valid/in_data in; in_ready, mem_we/mem_addr/mem_wdata,
//              busy/done/error, words_written, cpu_reset out (all registered)
module imem_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int BASE_WORD  = 0
) (
    input logic clk,
    input logic rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

    // Largest legal word count: the image must fit between BASE_WORD and the top of memory.
    localparam logic [32:0] LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_WORD);
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           n_q, n_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   ww_q, ww_d;
    logic                  we_q, we_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  take;
    logic                  last;
    logic [31:0]           word;

    always_comb begin
        take      = bus.in_valid && rdy_q;
        last      = lane_q == 2'd3;
        // Bytes shift in from the top so the first byte ends up in bits [7:0].
        word      = {bus.in_data, asm_q[31:8]};
        state_d   = state_q;
        lane_d    = take ? lane_q + 2'd1 : lane_q;
        n_d       = n_q;
        asm_d     = asm_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        ww_d      = ww_q;
        we_d      = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d = HDR;
                    lane_d  = 2'd0;
                    ww_d    = '0;
                end
            end
            HDR: begin
                if (take) begin
                    n_d = {bus.in_data, n_q[31:8]};
                    // Lane counter wraps to 0 here, so DATA starts on lane 0.
                    if (last)
                        state_d = n_d == 32'd0 ? DONE : {1'b0, n_d} > LIMIT ? ERR : DATA;
                end
            end
            DATA: begin
                if (take) begin
                    asm_d = word;
                    if (last) begin
                        we_d    = 1'b1;
                        wdata_d = word;
                        addr_d  = ADDR_WIDTH'(BASE_WORD) + ww_q[ADDR_WIDTH-1:0];
                        ww_d    = ww_q + ONE;
                        if (32'(ww_d) == n_q)
                            state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d     = state_d == HDR || state_d == DATA;
        busy_d    = state_d == HDR || state_d == DATA;
        done_d    = state_d == DONE;
        err_d     = state_d == ERR;
        cpu_rst_d = state_d != DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            n_q       <= '0;
            asm_q     <= '0;
            wdata_q   <= '0;
            addr_q    <= ADDR_WIDTH'(BASE_WORD);
            ww_q      <= '0;
            we_q      <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            n_q       <= n_d;
            asm_q     <= asm_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            ww_q      <= ww_d;
            we_q      <= we_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign bus.in_ready      = rdy_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = err_q;
    assign bus.words_written = ww_q;
    assign bus.cpu_reset     = cpu_rst_q;
endmodule
